// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite memory target: byte-strobed word RAM behind independent write and read FSMs.
// Out-of-range accesses answer DECERR and never touch the RAM.
module axi_lite_ram_slave #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rvalid_o,
  input  logic                rready_i
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  // The subtraction wraps for addresses below the base, so both bounds are checked.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  w_state_t            w_state_reg;
  logic                awready_reg;
  logic                wready_reg;
  logic                bvalid_reg;
  logic [1:0]          bresp_reg;
  logic [ADDR_W-1:0]   aw_addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [BYTES-1:0]    wstrb_reg;

  r_state_t            r_state_reg;
  logic                arready_reg;
  logic                rvalid_reg;
  logic [1:0]          rresp_reg;
  logic                rd_ok_reg;
  logic [DATA_W-1:0]   rd_word;

  logic                aw_fire;
  logic                w_fire;
  logic                ar_fire;
  logic                wr_commit;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [BYTES-1:0]    wr_strb;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    ar_idx;

  assign aw_fire = awvalid_i && awready_reg;
  assign w_fire  = wvalid_i && wready_reg;
  assign ar_fire = arvalid_i && arready_reg;

  // Commit uses live bus values for whichever half arrives last, latched values otherwise.
  always_comb begin
    wr_commit = 1'b0;
    wr_addr   = awaddr_i;
    wr_data   = wdata_i;
    wr_strb   = wstrb_i;
    case (w_state_reg)
      W_IDLE:    wr_commit = aw_fire && w_fire;
      W_WAIT_W: begin
        wr_addr   = aw_addr_reg;
        wr_commit = w_fire;
      end
      W_WAIT_AW: begin
        wr_data   = wdata_reg;
        wr_strb   = wstrb_reg;
        wr_commit = aw_fire;
      end
      default:   wr_commit = 1'b0;
    endcase
  end

  assign wr_en  = rst && wr_commit && in_range(wr_addr);
  assign wr_idx = word_idx(wr_addr);
  assign ar_idx = word_idx(araddr_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b1;
      wready_reg  <= 1'b1;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      case (w_state_reg)
        W_IDLE, W_WAIT_W, W_WAIT_AW: begin
          if (wr_commit) begin
            w_state_reg <= W_RESP;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= in_range(wr_addr) ? RESP_OKAY : RESP_DECERR;
          end else if (w_state_reg == W_IDLE && aw_fire) begin
            aw_addr_reg <= awaddr_i;
            awready_reg <= 1'b0;
            w_state_reg <= W_WAIT_W;
          end else if (w_state_reg == W_IDLE && w_fire) begin
            wdata_reg   <= wdata_i;
            wstrb_reg   <= wstrb_i;
            wready_reg  <= 1'b0;
            w_state_reg <= W_WAIT_AW;
          end
        end
        W_RESP: begin
          if (bready_i) begin
            w_state_reg <= W_IDLE;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            bvalid_reg  <= 1'b0;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rd_ok_reg   <= 1'b0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_fire) begin
            r_state_reg <= R_RESP;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rd_ok_reg   <= in_range(araddr_i);
            rresp_reg   <= in_range(araddr_i) ? RESP_OKAY : RESP_DECERR;
          end
        end
        R_RESP: begin
          if (rready_i) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b1;
            rvalid_reg  <= 1'b0;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // One RAM per byte lane; the registered read samples before the same-edge write lands.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_byte;

    always_ff @(posedge clk) begin
      if (wr_en && wr_strb[gi]) begin
        lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
      end
      if (ar_fire) begin
        rd_byte <= lane_mem[ar_idx];
      end
    end

    assign rd_word[gi*8 +: 8] = rd_byte;
  end

  assign awready_o = awready_reg;
  assign wready_o  = wready_reg;
  assign bvalid_o  = bvalid_reg;
  assign bresp_o   = bresp_reg;
  assign arready_o = arready_reg;
  assign rvalid_o  = rvalid_reg;
  assign rresp_o   = rresp_reg;
  assign rdata_o   = rd_ok_reg ? rd_word : '0;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed bench for axi_lite_ram_slave (DATA_W=32, DEPTH=256, base 0x1000).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_axi_lite_ram_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int errors;
  int checks;

  axi_lite_ram_slave #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (256),
    .BASE_ADDR(BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .awaddr_i (awaddr),
    .awvalid_i(awvalid),
    .awready_o(awready),
    .wdata_i  (wdata),
    .wstrb_i  (wstrb),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .bresp_o  (bresp),
    .bvalid_o (bvalid),
    .bready_i (bready),
    .araddr_i (araddr),
    .arvalid_i(arvalid),
    .arready_o(arready),
    .rdata_o  (rdata),
    .rresp_o  (rresp),
    .rvalid_o (rvalid),
    .rready_i (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL write_accept addr=%h got no ready in 20 cycles", addr); end
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL write_bvalid addr=%h got no bvalid in 20 cycles", addr); end
    resp = bresp;
    step();
    bready = 1'b0;
    $display("write addr=%h data=%h strb=%h -> bresp=%b", addr, data, strb, resp);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL read_accept addr=%h got no arready in 20 cycles", addr); end
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL read_rvalid addr=%h got no rvalid in 20 cycles", addr); end
    data = rdata; resp = rresp;
    step();
    rready = 1'b0;
    $display("read  addr=%h -> rdata=%h rresp=%b", addr, data, resp);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL reset_readies got=%b want=111", {awready, wready, arready}); end
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin errors++; $display("FAIL reset_valids got=%b want=00", {bvalid, rvalid}); end
    checks++;
    if ({bresp, rresp} !== 4'b0000) begin errors++; $display("FAIL reset_resps got=%b want=0000", {bresp, rresp}); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h want=00000000", rdata); end
    rst = 1'b1;
    step();
    $display("reset done");
  endtask

  task automatic test_simultaneous();
    awaddr = BASE + 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL sim_bresp got bvalid,bresp=%b want=100", {bvalid, bresp}); end
    checks++;
    if ({awready, wready} !== 2'b00) begin errors++; $display("FAIL sim_resp_readies got=%b want=00", {awready, wready}); end
    step();
    bready = 1'b0;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin errors++; $display("FAIL sim_b_done got=%b want=011", {bvalid, awready, wready}); end
    araddr = BASE + 32'h10; arvalid = 1'b1; rready = 1'b1;
    step();
    arvalid = 1'b0;
    checks++;
    if ({rvalid, arready, rresp} !== 4'b1000) begin errors++; $display("FAIL sim_rvalid got rvalid,arready,rresp=%b want=1000", {rvalid, arready, rresp}); end
    checks++;
    if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_rdata got=%h want=deadbeef", rdata); end
    step();
    rready = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin errors++; $display("FAIL sim_r_done got=%b want=01", {rvalid, arready}); end
    $display("simultaneous write/read at %h done", BASE + 32'h10);
  endtask

  task automatic test_w_first();
    logic [31:0] d;
    logic [1:0]  r;
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    step();
    wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({awready, wready, bvalid} !== 3'b100) begin errors++; $display("FAIL wfirst_wait%0d got aw,w,b=%b want=100", k, {awready, wready, bvalid}); end
      step();
    end
    awaddr = BASE + 32'h20; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL wfirst_bresp got=%b want=100", {bvalid, bresp}); end
    step();
    bready = 1'b0;
    do_write(BASE + 32'h20, 32'hAABBCCDD, 4'h5, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL strb5_bresp got=%b want=00", r); end
    do_read(BASE + 32'h20, d, r);
    checks++;
    if (d !== 32'h11BB33DD || r !== 2'b00) begin errors++; $display("FAIL strb5_readback got=%h/%b want=11bb33dd/00", d, r); end
  endtask

  task automatic test_aw_first();
    logic [31:0] d;
    logic [1:0]  r;
    awaddr = BASE + 32'h24; awvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({awready, wready, bvalid} !== 3'b010) begin errors++; $display("FAIL awfirst_wait%0d got aw,w,b=%b want=010", k, {awready, wready, bvalid}); end
      step();
    end
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL awfirst_bresp got=%b want=100", {bvalid, bresp}); end
    step();
    bready = 1'b0;
    do_read(BASE + 32'h24, d, r);
    checks++;
    if (d !== 32'hCAFEF00D || r !== 2'b00) begin errors++; $display("FAIL awfirst_readback got=%h/%b want=cafef00d/00", d, r); end
  endtask

  task automatic test_decerr();
    logic [31:0] d;
    logic [1:0]  r;
    do_write(BASE, 32'h0A0B0C0D, 4'hF, r);
    do_write(BASE + 32'h3FC, 32'h5A5A5A5A, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL last_word_bresp got=%b want=00", r); end
    do_write(BASE + 32'h400, 32'h12345678, 4'hF, r);
    checks++;
    if (r !== 2'b11) begin errors++; $display("FAIL above_range_bresp got=%b want=11", r); end
    do_write(BASE - 32'h4, 32'h87654321, 4'hF, r);
    checks++;
    if (r !== 2'b11) begin errors++; $display("FAIL below_range_bresp got=%b want=11", r); end
    do_read(BASE, d, r);
    checks++;
    if (d !== 32'h0A0B0C0D || r !== 2'b00) begin errors++; $display("FAIL word0_intact got=%h/%b want=0a0b0c0d/00", d, r); end
    do_read(BASE + 32'h3FC, d, r);
    checks++;
    if (d !== 32'h5A5A5A5A || r !== 2'b00) begin errors++; $display("FAIL lastword_intact got=%h/%b want=5a5a5a5a/00", d, r); end
    do_read(BASE + 32'h400, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b11) begin errors++; $display("FAIL above_range_read got=%h/%b want=00000000/11", d, r); end
    do_read(BASE - 32'h4, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b11) begin errors++; $display("FAIL below_range_read got=%h/%b want=00000000/11", d, r); end
    do_read(BASE + 32'h13, d, r);
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin errors++; $display("FAIL unaligned_read got=%h/%b want=deadbeef/00", d, r); end
  endtask

  task automatic test_backpressure();
    awaddr = BASE + 32'h400; wdata = 32'h0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b11100) begin errors++; $display("FAIL bhold%0d got b,resp,aw,w=%b want=11100", k, {bvalid, bresp, awready, wready}); end
      step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin errors++; $display("FAIL bhold_release got=%b want=011", {bvalid, awready, wready}); end
    araddr = BASE + 32'h20; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({rvalid, arready, rresp} !== 4'b1000 || rdata !== 32'h11BB33DD) begin
        errors++; $display("FAIL rhold%0d got v,ar,resp=%b data=%h want=1000 11bb33dd", k, {rvalid, arready, rresp}, rdata);
      end
      step();
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin errors++; $display("FAIL rhold_release got=%b want=01", {rvalid, arready}); end
    $display("backpressure hold checks done");
  endtask

  task automatic test_read_before_write();
    logic [31:0] d;
    logic [1:0]  r;
    do_write(BASE + 32'h30, 32'h1, 4'hF, r);
    araddr = BASE + 32'h30; arvalid = 1'b1; rready = 1'b1;
    awaddr = BASE + 32'h30; wdata = 32'h2; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1) begin errors++; $display("FAIL rbw_old got v=%b data=%h want=1 00000001", rvalid, rdata); end
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin errors++; $display("FAIL rbw_bresp got=%b want=100", {bvalid, bresp}); end
    step();
    rready = 1'b0; bready = 1'b0;
    do_read(BASE + 32'h30, d, r);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL rbw_new got=%h want=00000002", d); end
  endtask

  task automatic test_zero_strb();
    logic [31:0] d;
    logic [1:0]  r;
    do_write(BASE + 32'h10, 32'hFFFFFFFF, 4'h0, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL zstrb_bresp got=%b want=00", r); end
    do_read(BASE + 32'h10, d, r);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL zstrb_readback got=%h want=deadbeef", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [3];
    int i;
    int cyc;
    logic hs;
    exp_data[0] = 32'h0000_0101; exp_data[1] = 32'h0202_0000; exp_data[2] = 32'h3030_3030;
    i = 0; cyc = 0;
    awaddr = BASE + 32'h40; wdata = exp_data[0]; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (i < 3 && cyc < 20) begin
      hs = awready && wready;
      step();
      cyc++;
      if (hs) begin
        i++;
        if (i < 3) begin awaddr = BASE + 32'h40 + 32'(4 * i); wdata = exp_data[i]; end
        else begin awvalid = 1'b0; wvalid = 1'b0; end
      end
    end
    checks++;
    if (i != 3 || cyc != 5) begin errors++; $display("FAIL b2b_write_cycles got=%0d writes in %0d cycles want=3 in 5", i, cyc); end
    step();
    bready = 1'b0;
    i = 0; cyc = 0;
    araddr = BASE + 32'h40; arvalid = 1'b1; rready = 1'b1;
    while (i < 3 && cyc < 20) begin
      hs = arready;
      step();
      cyc++;
      if (hs) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp_data[i]) begin errors++; $display("FAIL b2b_read%0d got v=%b data=%h want=1 %h", i, rvalid, rdata, exp_data[i]); end
        i++;
        if (i < 3) araddr = BASE + 32'h40 + 32'(4 * i);
        else arvalid = 1'b0;
      end
    end
    checks++;
    if (i != 3 || cyc != 5) begin errors++; $display("FAIL b2b_read_cycles got=%0d reads in %0d cycles want=3 in 5", i, cyc); end
    step();
    rready = 1'b0;
    $display("back-to-back: 3 writes and 3 reads done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    do_write(BASE + 32'h50, 32'h55555555, 4'hF, r);
    awaddr = BASE + 32'h50; awvalid = 1'b1;
    araddr = BASE + 32'h10; arvalid = 1'b1; rready = 1'b0; bready = 1'b0;
    step();
    awvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if ({awready, wready, rvalid, arready} !== 4'b0110) begin errors++; $display("FAIL midrst_setup got aw,w,rv,ar=%b want=0110", {awready, wready, rvalid, arready}); end
    wdata = 32'h66666666; wstrb = 4'hF; wvalid = 1'b1; rst = 1'b0;
    step();
    wvalid = 1'b0; rst = 1'b1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin errors++; $display("FAIL midrst_state got aw,w,ar,b,r=%b want=11100", {awready, wready, arready, bvalid, rvalid}); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got=%h want=00000000", rdata); end
    do_read(BASE + 32'h50, d, r);
    checks++;
    if (d !== 32'h55555555) begin errors++; $display("FAIL midrst_no_commit got=%h want=55555555", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_simultaneous();
    test_w_first();
    test_aw_first();
    test_decerr();
    test_backpressure();
    test_read_before_write();
    test_zero_strb();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
